// File: rtl/proc_phase_seq.sv
// Processor phase sequencer: walks the multi-cycle datapath through FETCH..WB with
// post-reset hold-off, stall hold, graceful halt and free-running activity counters.
module proc_phase_seq #(
  parameter int unsigned RESET_HOLD      = 2,
  parameter int unsigned CYCLE_CNT_WIDTH = 32,
  parameter int unsigned INSTR_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       halt_req,
  input  logic                       clr_cnt,
  output logic [2:0]                 state,
  output logic [4:0]                 phase_oh,
  output logic                       instr_done,
  output logic                       halted,
  output logic [CYCLE_CNT_WIDTH-1:0] cycle_cnt,
  output logic [INSTR_CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_e;

  // A hold of 0 is treated as 1, so the last INIT count is always RESET_HOLD-1 or 0.
  localparam logic [3:0] HOLD_LAST = (RESET_HOLD == 0) ? 4'd0 : 4'(RESET_HOLD - 1);
  localparam logic [3:0] HOLD_ONE  = 4'd1;
  localparam logic [CYCLE_CNT_WIDTH-1:0] CYC_ONE = CYCLE_CNT_WIDTH'(1);
  localparam logic [INSTR_CNT_WIDTH-1:0] INS_ONE = INSTR_CNT_WIDTH'(1);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt, hold_d;
  logic       halt_pending, pending_d;
  logic       active;
  logic       retire;

  assign active = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)   || (state_q == S_WB);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    hold_d    = '0;
    pending_d = halt_pending;
    retire    = 1'b0;
    if (active) pending_d = halt_pending | halt_req;
    case (state_q)
      S_INIT: begin
        if (hold_cnt == HOLD_LAST) state_d = S_FETCH;
        else                       hold_d  = hold_cnt + HOLD_ONE;
      end
      S_FETCH:  if (!stall) state_d = S_DECODE;
      S_DECODE: if (!stall) state_d = S_EXEC;
      S_EXEC:   if (!stall) state_d = S_MEM;
      S_MEM:    if (!stall) state_d = S_WB;
      S_WB: begin
        if (!stall) begin
          retire  = 1'b1;
          state_d = (halt_pending || halt_req) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default: begin
        state_d   = S_INIT;
        pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      hold_cnt     <= '0;
      halt_pending <= 1'b0;
      instr_done   <= 1'b0;
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      hold_cnt     <= hold_d;
      halt_pending <= pending_d;
      instr_done   <= retire;
      if (active) begin
        if (clr_cnt) begin
          cycle_cnt <= '0;
          instr_cnt <= '0;
        end else begin
          cycle_cnt <= cycle_cnt + CYC_ONE;
          if (retire) instr_cnt <= instr_cnt + INS_ONE;
        end
      end
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALTED);

  always_comb begin
    phase_oh = 5'b00000;
    case (state_q)
      S_FETCH:  phase_oh = 5'b00001;
      S_DECODE: phase_oh = 5'b00010;
      S_EXEC:   phase_oh = 5'b00100;
      S_MEM:    phase_oh = 5'b01000;
      S_WB:     phase_oh = 5'b10000;
      default:  phase_oh = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_proc_phase_seq.sv
// Self-checking bench for proc_phase_seq: directed scenarios followed by randomized
// stall/halt/clear/reset traffic, all compared against a behavioural phase model.
module tb_proc_phase_seq;

  localparam int unsigned HOLD = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, halt_req = 1'b0, clr_cnt = 1'b0;
  logic [2:0]    state;
  logic [4:0]    phase_oh;
  logic          instr_done, halted;
  logic [CW-1:0] cycle_cnt;
  logic [IW-1:0] instr_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase number 0=INIT, 1..5=FETCH..WB, 6=HALTED.
  int          m_state, m_hold;
  bit          m_pending, m_done;
  int unsigned m_cyc, m_ins;

  proc_phase_seq #(
    .RESET_HOLD(HOLD), .CYCLE_CNT_WIDTH(CW), .INSTR_CNT_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .clr_cnt(clr_cnt),
    .state(state), .phase_oh(phase_oh), .instr_done(instr_done), .halted(halted),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_pending = 0; m_done = 0; m_cyc = 0; m_ins = 0;
  endtask

  task automatic model_edge();
    bit retire;
    int tgt;
    tgt = (HOLD == 0) ? 1 : int'(HOLD);
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_state == 0) begin
      m_done = 0;
      if (m_hold + 1 >= tgt) begin m_state = 1; m_hold = 0; end
      else m_hold++;
    end else if (m_state >= 1 && m_state <= 5) begin
      retire = (m_state == 5) && !stall;
      if (clr_cnt) begin
        m_cyc = 0; m_ins = 0;
      end else begin
        m_cyc = (m_cyc + 1) % (1 << CW);
        m_ins = m_ins + (retire ? 1 : 0);
      end
      if (!stall)
        m_state = (m_state == 5) ? ((m_pending || halt_req) ? 6 : 1) : m_state + 1;
      m_pending = m_pending | halt_req;
      m_done = retire;
    end else begin
      m_done = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] oh;
    oh = (m_state >= 1 && m_state <= 5) ? 5'(1 << (m_state - 1)) : 5'b0;
    chk({tag, ".state"},  32'(state),      32'(m_state));
    chk({tag, ".phase"},  32'(phase_oh),   32'(oh));
    chk({tag, ".done"},   32'(instr_done), 32'(m_done));
    chk({tag, ".halted"}, 32'(halted),     32'(m_state == 6));
    chk({tag, ".cyc"},    32'(cycle_cnt),  m_cyc);
    chk({tag, ".ins"},    32'(instr_cnt),  m_ins);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called just after an edge; asserts reset mid-cycle and releases it before FETCH.
  task automatic reset_seq(input string tag);
    #1 rst = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    step({tag, ".rst_low"});
    rst = 1'b1;
    step({tag, ".hold1"});
    step({tag, ".hold2"});
  endtask

  initial begin
    model_reset();
    // 1. Reset and hold-off
    #1 rst = 1'b0;
    #1 check_all("t1.reset");
    repeat (3) step("t1.rst_low");
    rst = 1'b1;
    step("t1.edge1");
    chk("t1.edge1_init", 32'(state), 32'd0);
    step("t1.edge2");
    chk("t1.fetch", 32'(state), 32'd1);
    chk("t1.fetch_oh", 32'(phase_oh), 32'b00001);
    chk("t1.fetch_cnt", 32'(cycle_cnt) | instr_cnt, 32'd0);

    // 2. Free run: 15 edges, retire pulses after edges 5, 10, 15
    for (int i = 1; i <= 15; i++) begin
      step("t2.run");
      chk("t2.done_pulse", 32'(instr_done), 32'((i % 5) == 0));
    end
    chk("t2.state", 32'(state), 32'd1);
    chk("t2.instr", instr_cnt, 32'd3);
    chk("t2.cycle", 32'(cycle_cnt), 32'd15);

    // 3. Stall for 3 edges in EXEC
    reset_seq("t3");
    repeat (2) step("t3.pre");
    stall = 1'b1;
    repeat (3) step("t3.stall");
    chk("t3.held_exec", 32'(state), 32'd3);
    stall = 1'b0;
    repeat (3) step("t3.post");
    chk("t3.instr", instr_cnt, 32'd1);
    chk("t3.cycle", 32'(cycle_cnt), 32'd8);
    chk("t3.done", 32'(instr_done), 32'd1);

    // 4. Halt request pulse during DECODE
    reset_seq("t4");
    step("t4.decode");
    halt_req = 1'b1;
    step("t4.halt_pulse");
    halt_req = 1'b0;
    repeat (3) step("t4.drain");
    chk("t4.state", 32'(state), 32'd6);
    chk("t4.halted", 32'(halted), 32'd1);
    chk("t4.instr", instr_cnt, 32'd1);
    chk("t4.cycle", 32'(cycle_cnt), 32'd5);
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom); halt_req = 1'($urandom); clr_cnt = 1'($urandom);
      step("t4.frozen");
    end
    stall = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    chk("t4.frozen_cyc", 32'(cycle_cnt), 32'd5);
    chk("t4.frozen_ins", instr_cnt, 32'd1);

    // 5. Asynchronous reset while in MEM with 13 cycles counted
    reset_seq("t5");
    repeat (13) step("t5.run");
    chk("t5.mem", 32'(state), 32'd4);
    chk("t5.cyc13", 32'(cycle_cnt), 32'd13);
    reset_seq("t5.midop");

    // 6. 4-bit cycle counter wrap, then clear on the retiring edge
    repeat (16) step("t6.wrap");
    chk("t6.wrap_zero", 32'(cycle_cnt), 32'd0);
    repeat (3) step("t6.to_wb");
    chk("t6.wb", 32'(state), 32'd5);
    clr_cnt = 1'b1;
    step("t6.clear");
    clr_cnt = 1'b0;
    chk("t6.clr_ins", instr_cnt, 32'd0);
    chk("t6.clr_done", 32'(instr_done), 32'd1);
    chk("t6.clr_state", 32'(state), 32'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      clr_cnt  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) reset_seq("rnd.reset");
      else step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
